// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_SIGN = 2'd3;

  localparam int unsigned BCD_DIGITS = 3;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per clock after i_start.
module bin_to_bcd_seq
  import seg_display_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_mag,
  output logic              o_done,
  output logic [3:0]        o_hund,
  output logic [3:0]        o_tens,
  output logic [3:0]        o_ones
);

  localparam int SR_W  = 4 * BCD_DIGITS + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_adj;
  logic [SR_W-1:0]  w_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  always_comb begin
    w_adj = r_sr;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (r_sr[DATA_W + 4*i +: 4] >= 4'd5)
        w_adj[DATA_W + 4*i +: 4] = r_sr[DATA_W + 4*i +: 4] + 4'd3;
    end
    w_shift = w_adj << 1;
  end

  // o_done flags the cycle whose closing edge performs the final shift,
  // so the parent can leave CONVERT on exactly that edge.
  assign o_done = r_active && (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_sr     <= {{(4*BCD_DIGITS){1'b0}}, i_mag};
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_sr  <= w_shift;
      r_cnt <= r_cnt + 1'b1;
      if (o_done)
        r_active <= 1'b0;
    end
  end

  assign o_hund = r_sr[DATA_W + 8 +: 4];
  assign o_tens = r_sr[DATA_W + 4 +: 4];
  assign o_ones = r_sr[DATA_W +: 4];

endmodule

// File: rtl/seg_display_scheduler.sv
// Accepts a signed result, converts it to BCD and scans it onto a 7-segment decoder.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero hundreds/tens slots.
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              value_valid,
  input  logic [DATA_W-1:0] value,
  output logic              value_ready,
  output logic              busy,
  output logic              en,
  output logic [1:0]        count,
  output logic [3:0]        num,
  output logic              sign
);

  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t            r_state;
  logic              r_sign_pend;
  logic [3:0]        r_ones;
  logic [3:0]        r_tens;
  logic [3:0]        r_hund;
  logic              r_disp_sign;
  logic              r_disp_valid;
  logic [TICK_W-1:0] r_tick;
  logic [1:0]        r_count;

  logic              w_accept;
  logic [DATA_W-1:0] w_mag;
  logic              w_done;
  logic [3:0]        w_hund;
  logic [3:0]        w_tens;
  logic [3:0]        w_ones;
  logic              w_blank;

  assign w_accept = value_valid && (r_state == IDLE);
  // Two's-complement negate of the most negative value yields 2^(DATA_W-1) unsigned.
  assign w_mag    = value[DATA_W-1] ? (~value + 1'b1) : value;

  bin_to_bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept),
    .i_mag   (w_mag),
    .o_done  (w_done),
    .o_hund  (w_hund),
    .o_tens  (w_tens),
    .o_ones  (w_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sign_pend  <= 1'b0;
      r_ones       <= '0;
      r_tens       <= '0;
      r_hund       <= '0;
      r_disp_sign  <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= CONVERT;
            r_sign_pend <= value[DATA_W-1];
          end
        end
        CONVERT: begin
          if (w_done)
            r_state <= COMMIT;
        end
        COMMIT: begin
          r_ones       <= w_ones;
          r_tens       <= w_tens;
          r_hund       <= w_hund;
          r_disp_sign  <= r_sign_pend;
          r_disp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick  <= '0;
      r_count <= '0;
    end else if (r_tick == TICK_W'(REFRESH_DIV - 1)) begin
      r_tick  <= '0;
      r_count <= r_count + 1'b1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  always_comb begin
    num = '0;
    case (r_count)
      DIG_ONES: num = r_ones;
      DIG_TENS: num = r_tens;
      DIG_HUND: num = r_hund;
      DIG_SIGN: num = '0;
      default:  num = '0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    if ((r_count == DIG_HUND) && (r_hund == 4'd0))
      w_blank = 1'b1;
    if ((r_count == DIG_TENS) && (r_hund == 4'd0) && (r_tens == 4'd0))
      w_blank = 1'b1;
  end
`else
  assign w_blank = 1'b0;
`endif

  assign value_ready = (r_state == IDLE);
  assign busy        = (r_state == CONVERT) || (r_state == COMMIT);
  assign count       = r_count;
  assign sign        = r_disp_sign;
  assign en          = r_disp_valid && !w_blank;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed self-checking bench for seg_display_scheduler (DATA_W=8, REFRESH_DIV=4).
module tb_seg_display_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       value_valid;
  logic [7:0] value;
  logic       value_ready;
  logic       busy;
  logic       en;
  logic [1:0] count;
  logic [3:0] num;
  logic       sign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_display_scheduler #(
    .DATA_W      (8),
    .REFRESH_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .busy        (busy),
    .en          (en),
    .count       (count),
    .num         (num),
    .sign        (sign)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dig(input logic [1:0] c, input logic [3:0] o,
                                     input logic [3:0] t, input logic [3:0] h);
    case (c)
      2'd0:    return o;
      2'd1:    return t;
      2'd2:    return h;
      default: return 4'd0;
    endcase
  endfunction

  task automatic wait_count(input logic [1:0] c);
    int n = 0;
    while (count !== c && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scan_reach", {14'd0, count}, {14'd0, c});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (value_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {15'd0, value_ready}, 16'd1);
  endtask

  task automatic check_slots(input string tag, input logic [3:0] o, input logic [3:0] t,
                             input logic [3:0] h, input logic s, input logic [3:0] en_exp);
    for (int c = 0; c < 4; c++) begin
      logic [1:0] cc;
      cc = c[1:0];
      wait_count(cc);
      chk({tag, "_num"},  {12'd0, num}, {12'd0, dig(cc, o, t, h)});
      chk({tag, "_sign"}, {15'd0, sign}, {15'd0, s});
      chk({tag, "_en"},   {15'd0, en},   {15'd0, en_exp[c]});
    end
  endtask

  // Drives value for exactly the accept cycle; returns at the negedge after E0.
  task automatic send(input logic [7:0] v);
    value_valid = 1'b1;
    value       = v;
    @(negedge clk);
    value_valid = 1'b0;
    value       = 8'h5A;
  endtask

  initial begin
    rst         = 1'b1;
    value_valid = 1'b0;
    value       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", {15'd0, value_ready}, 16'd1);
    chk("rst_busy",  {15'd0, busy},        16'd0);
    chk("rst_en",    {15'd0, en},          16'd0);
    chk("rst_count", {14'd0, count},       16'd0);
    chk("rst_num",   {12'd0, num},         16'd0);
    chk("rst_sign",  {15'd0, sign},        16'd0);

    repeat (3) @(negedge clk);
    chk("scan_hold", {14'd0, count}, 16'd0);
    @(negedge clk);
    chk("scan_1", {14'd0, count}, 16'd1);
    repeat (4) @(negedge clk);
    chk("scan_2", {14'd0, count}, 16'd2);
    repeat (4) @(negedge clk);
    chk("scan_3", {14'd0, count}, 16'd3);
    repeat (4) @(negedge clk);
    chk("scan_wrap", {14'd0, count}, 16'd0);
    chk("idle_en",    {15'd0, en},          16'd0);
    chk("idle_ready", {15'd0, value_ready}, 16'd1);

    send(8'd123);
    for (int i = 0; i < 9; i++) begin
      chk("v123_busy",  {15'd0, busy},        16'd1);
      chk("v123_ready", {15'd0, value_ready}, 16'd0);
      chk("v123_dark",  {15'd0, en},          16'd0);
      @(negedge clk);
    end
    chk("v123_done_busy",  {15'd0, busy},        16'd0);
    chk("v123_done_ready", {15'd0, value_ready}, 16'd1);
    chk("v123_done_en",    {15'd0, en},          16'd1);
    check_slots("v123", 4'd3, 4'd2, 4'd1, 1'b0, 4'b1111);

    send(8'h80);
    wait_ready();
    check_slots("vm128", 4'd8, 4'd2, 4'd1, 1'b1, 4'b1111);

    send(8'd0);
    wait_ready();
    check_slots("v0", 4'd0, 4'd0, 4'd0, 1'b0, 4'b1111);

    value_valid = 1'b1;
    value       = 8'd45;
    @(negedge clk);
    value = 8'd99;
    for (int i = 0; i < 9; i++) begin
      chk("v45_ready", {15'd0, value_ready}, 16'd0);
      chk("v45_busy",  {15'd0, busy},        16'd1);
      @(negedge clk);
    end
    chk("v45_ready_up", {15'd0, value_ready}, 16'd1);
    chk("v45_num",      {12'd0, num}, {12'd0, dig(count, 4'd5, 4'd4, 4'd0)});
    chk("v45_sign",     {15'd0, sign}, 16'd0);
    @(negedge clk);
    value_valid = 1'b0;
    chk("v99_taken",    {15'd0, busy}, 16'd1);
    chk("v45_persist",  {12'd0, num}, {12'd0, dig(count, 4'd5, 4'd4, 4'd0)});
    chk("v45_persist_en", {15'd0, en}, 16'd1);
    wait_ready();
    check_slots("v99", 4'd9, 4'd9, 4'd0, 1'b0, 4'b1111);

    send(8'd77);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", {15'd0, value_ready}, 16'd1);
    chk("abort_busy",  {15'd0, busy},        16'd0);
    chk("abort_en",    {15'd0, en},          16'd0);
    chk("abort_num",   {12'd0, num},         16'd0);
    chk("abort_sign",  {15'd0, sign},        16'd0);
    chk("abort_count", {14'd0, count},       16'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_commit", {15'd0, en},   16'd0);
    chk("abort_idle_busy", {15'd0, busy}, 16'd0);
    check_slots("abort", 4'd0, 4'd0, 4'd0, 1'b0, 4'b0000);

    send(8'd7);
    wait_ready();
`ifdef LEADING_ZERO_BLANK_EN
    check_slots("v7", 4'd7, 4'd0, 4'd0, 1'b0, 4'b1001);
`else
    check_slots("v7", 4'd7, 4'd0, 4'd0, 1'b0, 4'b1111);
`endif

    send(8'd105);
    wait_ready();
    check_slots("v105", 4'd5, 4'd0, 4'd1, 1'b0, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
